// File: rtl/slave_fifo.sv
// slave_fifo: buffered write-request slave at the end of an arbiter grant path.
// Accepted writes (req/data) land in a DEPTH-entry first-word-fall-through
// FIFO and are acknowledged one cycle later. A local consumer drains the
// buffer through rd_en/rd_data. The block also keeps a copy of the most
// recently accepted word, sticky overflow/underflow flags and a wrapping
// accepted-write counter.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req, data      write attempt each cycle req=1
//   ack            high one cycle after each accepted write
//   last_data      most recently accepted word
//   rd_en          pop the head entry
//   rd_data        head entry, 0 while empty
//   rd_valid       FIFO non-empty
//   full, empty    level == DEPTH / level == 0
//   level          occupied entries
//   overflow       sticky: a write was dropped
//   underflow      sticky: rd_en while empty
//   clr_err        clears both sticky flags (a same-cycle new error wins)
//   accept_cnt     accepted-write counter, wraps modulo 2^CNT_W
module slave_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic [DATA_W-1:0]            data,
    output logic                         ack,
    output logic [DATA_W-1:0]            last_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err,
    output logic [CNT_W-1:0]             accept_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic rd_fire;
    logic accept;
    logic drop;
    logic rd_empty_err;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign rd_valid = !empty;

    assign rd_fire      = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign accept       = req && (!full || rd_fire);
    assign drop         = req && !accept;
    assign rd_empty_err = rd_en && empty;

    // Masked while empty so uninitialised storage never reaches the output.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ack        <= 1'b0;
            last_data  <= '0;
            accept_cnt <= '0;
        end else begin
            ack <= accept;
            if (accept) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                last_data  <= data;
                accept_cnt <= accept_cnt + CNT_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, rd_fire})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags: a new event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_empty_err) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
